pipeline_exec_ctrl: RTL and testbench

- Sequences the execution of the pipelined processor on behalf of the debug unit.
- Turns RUN / STEP / STOP / CLEAR commands into the pipeline `start` pulse and global `enable`.
- After the program counter stage reports a halt, keeps the pipeline enabled until in-flight instructions drain to writeback.
- Counts executed clock cycles for readback.
- Sits between the debug command decoder and the IF-stage PC / pipeline register enables.

---
 rtl/pipeline_exec_ctrl_if.sv | 26 ++
 rtl/pipeline_exec_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_exec_ctrl_if.sv
// Debug-command / pipeline-control bundle for pipeline_exec_ctrl.
// master = debug command decoder + IF halt source, slave = execution controller.
interface pipeline_exec_ctrl_if #(
    parameter int unsigned CYCLE_CNT_SIZE = 32
) ();
    logic                      i_cmd_valid;
    logic [1:0]                i_cmd;
    logic                      o_cmd_ready;
    logic                      i_halt;
    logic                      o_start;
    logic                      o_enable;
    logic                      o_busy;
    logic                      o_done;
    logic                      o_timeout;
    logic [CYCLE_CNT_SIZE-1:0] o_cycle_count;

    modport master (
        output i_cmd_valid, i_cmd, i_halt,
        input  o_cmd_ready, o_start, o_enable, o_busy, o_done, o_timeout, o_cycle_count
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_halt,
        output o_cmd_ready, o_start, o_enable, o_busy, o_done, o_timeout, o_cycle_count
    );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Debug-driven execution sequencer: RUN/STEP/STOP/CLEAR -> PC start pulse and pipeline enable,
// drains in-flight instructions after halt, counts enabled cycles. Optional EXEC_CTRL_WATCHDOG_EN.
module pipeline_exec_ctrl #(
    parameter int unsigned CYCLE_CNT_SIZE  = 32,
    parameter int unsigned DRAIN_CYCLES    = 4,
    parameter int unsigned WATCHDOG_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pipeline_exec_ctrl_if.slave  bus
);
    localparam int unsigned DRAIN_W = 4;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_PAUSE, S_STEP_EXEC, S_RUN, S_DRAIN, S_DONE
    } state_t;

    if (DRAIN_CYCLES == 0 || DRAIN_CYCLES > 15 || WATCHDOG_CYCLES == 0) begin : g_param_check
        $error("pipeline_exec_ctrl: DRAIN_CYCLES must be 1..15 and WATCHDOG_CYCLES >= 1");
    end

    state_t                    state_q, state_d;
    logic                      mode_run_q, mode_run_d;
    logic [DRAIN_W-1:0]        drain_q, drain_d;
    logic [CYCLE_CNT_SIZE-1:0] count_q, count_d;
    logic                      start_q, enable_q, done_q, ready_q, busy_q;
    logic                      cmd_acc_c;
    logic                      clr_c;
    logic                      wd_hit_c;

    assign cmd_acc_c = bus.i_cmd_valid & ready_q;

`ifdef EXEC_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Hit means the current enabled cycle is the WATCHDOG_CYCLES-th since START.
    assign wd_hit_c = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));

    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (state_q == S_START) begin
            wd_d = '0;
        end else if (enable_q && (wd_q != '1)) begin
            wd_d = wd_q + WD_W'(1);
        end
        if (clr_c) begin
            timeout_d = 1'b0;
        end
        if (wd_hit_c && !bus.i_halt && ((state_q == S_RUN) || (state_q == S_STEP_EXEC))) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    assign wd_hit_c      = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    // Next-state logic; halt (or watchdog) in RUN wins over a simultaneous STOP.
    always_comb begin
        state_d    = state_q;
        mode_run_d = mode_run_q;
        drain_d    = drain_q;
        clr_c      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_acc_c) begin
                    unique case (bus.i_cmd)
                        CMD_RUN:   begin state_d = S_START; mode_run_d = 1'b1; clr_c = 1'b1; end
                        CMD_STEP:  begin state_d = S_START; mode_run_d = 1'b0; clr_c = 1'b1; end
                        CMD_CLEAR: clr_c = 1'b1;
                        default:   ;
                    endcase
                end
            end
            S_START: state_d = mode_run_q ? S_RUN : S_PAUSE;
            S_PAUSE: begin
                if (cmd_acc_c) begin
                    unique case (bus.i_cmd)
                        CMD_STEP:  state_d = S_STEP_EXEC;
                        CMD_RUN:   state_d = S_RUN;
                        CMD_CLEAR: begin state_d = S_IDLE; clr_c = 1'b1; end
                        default:   ;
                    endcase
                end
            end
            S_STEP_EXEC: begin
                if (bus.i_halt || wd_hit_c) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_RUN: begin
                if (bus.i_halt || wd_hit_c) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (cmd_acc_c && (bus.i_cmd == CMD_STOP)) begin
                    state_d = S_PAUSE;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating count of enabled cycles.
    always_comb begin
        count_d = count_q;
        if (clr_c) begin
            count_d = '0;
        end else if (enable_q && (count_q != '1)) begin
            count_d = count_q + CYCLE_CNT_SIZE'(1);
        end
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            mode_run_q <= 1'b0;
            drain_q    <= '0;
            count_q    <= '0;
            start_q    <= 1'b0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_run_q <= mode_run_d;
            drain_q    <= drain_d;
            count_q    <= count_d;
            start_q    <= (state_d == S_START);
            enable_q   <= (state_d == S_RUN) || (state_d == S_STEP_EXEC) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);
            ready_q    <= (state_d == S_IDLE) || (state_d == S_PAUSE) || (state_d == S_RUN);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign bus.o_start       = start_q;
    assign bus.o_enable      = enable_q;
    assign bus.o_done        = done_q;
    assign bus.o_cmd_ready   = ready_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_cycle_count = count_q;
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl; expected cycle counts are queued per command
// sequence and popped when the DUT pulses o_done.
module tb_pipeline_exec_ctrl;
    localparam int unsigned CW = 4;
    localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_STOP = 2'b10, C_CLEAR = 2'b11;

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    pipeline_exec_ctrl_if #(.CYCLE_CNT_SIZE(CW)) bus_if ();

    pipeline_exec_ctrl #(
        .CYCLE_CNT_SIZE (CW),
        .DRAIN_CYCLES   (4),
        .WATCHDOG_CYCLES(20)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus_if)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int en_cnt = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (bus_if.o_enable) en_cnt++;
    endtask

    task automatic send(input logic [1:0] c);
        bus_if.i_cmd_valid = 1'b1;
        bus_if.i_cmd       = c;
        tick();
        bus_if.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_cyc);
        int n;
        int exp_cnt;
        n = 0;
        while (!bus_if.o_done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(bus_if.o_done), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            exp_cnt = exp_q.pop_front();
            chk({tag, "_count"}, 32'(bus_if.o_cycle_count), 32'(exp_cnt));
        end
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        i_reset            = 1'b1;
        bus_if.i_cmd_valid = 1'b0;
        bus_if.i_cmd       = C_RUN;
        bus_if.i_halt      = 1'b0;
        tick();
        tick();
        chk("rst_ready",   32'(bus_if.o_cmd_ready),   32'd1);
        chk("rst_start",   32'(bus_if.o_start),       32'd0);
        chk("rst_enable",  32'(bus_if.o_enable),      32'd0);
        chk("rst_done",    32'(bus_if.o_done),        32'd0);
        chk("rst_busy",    32'(bus_if.o_busy),        32'd0);
        chk("rst_timeout", 32'(bus_if.o_timeout),     32'd0);
        chk("rst_count",   32'(bus_if.o_cycle_count), 32'd0);
        i_reset = 1'b0;
        tick();

        // STOP in IDLE is accepted and ignored
        send(C_STOP);
        chk("idle_stop_busy",  32'(bus_if.o_busy),      32'd0);
        chk("idle_stop_ready", 32'(bus_if.o_cmd_ready), 32'd1);

        // RUN at edge 0, halt in 10th enabled cycle (cycle 11)
        exp_q.push_back(14);
        cyc    = 0;
        en_cnt = 0;
        send(C_RUN);
        chk("run_start_c1",  32'(bus_if.o_start),  32'd1);
        chk("run_enable_c1", 32'(bus_if.o_enable), 32'd0);
        tick();
        chk("run_enable_c2", 32'(bus_if.o_enable), 32'd1);
        chk("run_start_c2",  32'(bus_if.o_start),  32'd0);
        while (cyc < 11) tick();
        bus_if.i_halt = 1'b1;
        tick();
        bus_if.i_halt = 1'b0;
        chk("run_drain_enable", 32'(bus_if.o_enable), 32'd1);
        wait_done("run_halt", 20, 16);
        chk("run_en_cycles", 32'(en_cnt), 32'd14);
        tick();
        chk("run_idle_busy",  32'(bus_if.o_busy),      32'd0);
        chk("run_idle_ready", 32'(bus_if.o_cmd_ready), 32'd1);
        chk("run_idle_done",  32'(bus_if.o_done),      32'd0);

        // STEP from IDLE clears the count, then three single steps
        send(C_STEP);
        chk("step_start",     32'(bus_if.o_start),       32'd1);
        chk("step_cnt_clear", 32'(bus_if.o_cycle_count), 32'd0);
        tick();
        chk("step_pause_en", 32'(bus_if.o_enable), 32'd0);
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            send(C_STEP);
            chk("step_pulse_on", 32'(bus_if.o_enable), 32'd1);
            tick();
            chk("step_pulse_off", 32'(bus_if.o_enable), 32'd0);
            tick();
        end
        chk("step_en_cycles", 32'(en_cnt),               32'd3);
        chk("step_count",     32'(bus_if.o_cycle_count), 32'd3);
        chk("step_busy",      32'(bus_if.o_busy),        32'd1);
        chk("step_ready",     32'(bus_if.o_cmd_ready),   32'd1);

        send(C_CLEAR);
        chk("pause_clear_busy",  32'(bus_if.o_busy),        32'd0);
        chk("pause_clear_count", 32'(bus_if.o_cycle_count), 32'd0);

        // Stop after 5 enabled cycles, pause 10, resume, halt after 3 more
        exp_q.push_back(12);
        send(C_RUN);
        tick();
        repeat (4) tick();
        send(C_STOP);
        chk("stop_count",  32'(bus_if.o_cycle_count), 32'd5);
        chk("stop_enable", 32'(bus_if.o_enable),      32'd0);
        en_cnt = 0;
        repeat (10) tick();
        chk("pause_no_enable", 32'(en_cnt),               32'd0);
        chk("pause_hold",      32'(bus_if.o_cycle_count), 32'd5);
        send(C_RUN);
        chk("resume_enable", 32'(bus_if.o_enable), 32'd1);
        tick();
        tick();
        bus_if.i_halt = 1'b1;
        tick();
        bus_if.i_halt = 1'b0;
        wait_done("stop_resume", 10, -1);
        tick();

        // Halt and STOP at the same edge: drain must complete
        exp_q.push_back(6);
        send(C_RUN);
        tick();
        tick();
        bus_if.i_halt      = 1'b1;
        bus_if.i_cmd_valid = 1'b1;
        bus_if.i_cmd       = C_STOP;
        en_cnt             = 0;
        tick();
        bus_if.i_halt      = 1'b0;
        bus_if.i_cmd_valid = 1'b0;
        chk("hs_drain_enable", 32'(bus_if.o_enable), 32'd1);
        wait_done("halt_stop", 10, -1);
        chk("hs_drain_cycles", 32'(en_cnt), 32'd4);
        tick();

        // 24 enabled cycles into a 4-bit counter: saturates at 15, no wrap
        exp_q.push_back(15);
        send(C_RUN);
        tick();
        repeat (19) tick();
        bus_if.i_halt = 1'b1;
        tick();
        bus_if.i_halt = 1'b0;
        wait_done("saturate", 10, -1);
        tick();
        chk("sat_hold", 32'(bus_if.o_cycle_count), 32'd15);

        send(C_CLEAR);
        chk("idle_clear_count", 32'(bus_if.o_cycle_count), 32'd0);
        chk("idle_clear_busy",  32'(bus_if.o_busy),        32'd0);

`ifdef EXEC_CTRL_WATCHDOG_EN
        // RUN without halt: watchdog forces drain after 20 enabled cycles
        exp_q.push_back(15);
        send(C_RUN);
        en_cnt = 0;
        wait_done("watchdog", 40, -1);
        chk("wd_en_cycles", 32'(en_cnt),           32'd24);
        chk("wd_timeout",   32'(bus_if.o_timeout), 32'd1);
        tick();
        chk("wd_sticky", 32'(bus_if.o_timeout), 32'd1);
        send(C_RUN);
        chk("wd_run_clears", 32'(bus_if.o_timeout), 32'd0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
`else
        chk("no_wd_timeout", 32'(bus_if.o_timeout), 32'd0);
`endif

        // Asynchronous reset in the middle of RUN
        send(C_RUN);
        repeat (3) tick();
        chk("mid_run_enable", 32'(bus_if.o_enable), 32'd1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_enable", 32'(bus_if.o_enable),      32'd0);
        chk("arst_count",  32'(bus_if.o_cycle_count), 32'd0);
        chk("arst_ready",  32'(bus_if.o_cmd_ready),   32'd1);
        chk("arst_done",   32'(bus_if.o_done),        32'd0);
        chk("arst_busy",   32'(bus_if.o_busy),        32'd0);
        tick();
        i_reset = 1'b0;
        tick();
        chk("post_rst_done", 32'(bus_if.o_done), 32'd0);
        chk("post_rst_busy", 32'(bus_if.o_busy), 32'd0);
        chk("sb_drained",    32'(exp_q.size()),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
